axi_stream_remove_header: RTL and testbench

AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

---
 rtl/axi_stream_remove_header.sv | 181 ++++++++++++++++++
 tb/tb_axi_stream_remove_header.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_remove_header.sv
// Strips a runtime-selected 1..W byte header from the front of each AXI-Stream packet,
// returning the header on its own channel and re-packing the payload MSB-aligned.
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header
);

    localparam int W  = DATA_BYTE_WD;
    localparam int CW = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

    state_t            state;
    logic [CW-1:0]     hdr_len;
    logic [CW-1:0]     resid_cnt;
    logic [DATA_WD-1:0] resid;

    logic              out_free;
    logic              hdr_free;
    logic              accept;

    int unsigned       k_in, h_n, r_n, first_t, body_t;
    logic [DATA_WD-1:0] data_m, first_rest, body_full, body_next, hdr_data;
    logic [W-1:0]      hdr_keep;

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [W-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < W; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [W-1:0] keep_top(input int unsigned n);
        logic [W-1:0] ones;
        ones = '1;
        return ones << (W - n);
    endfunction

    assign out_free    = !valid_out || ready_out;
    assign hdr_free    = !valid_header || ready_header;
    assign ready_strip = !rst && (state == IDLE);
    assign ready_in    = !rst && (((state == FIRST) && hdr_free && out_free) ||
                                  ((state == BODY) && out_free));
    assign accept      = valid_in && ready_in;

    // Residual bytes are kept MSB-aligned so they prefix the next output beat directly.
    always_comb begin
        k_in = 0;
        for (int unsigned i = 0; i < W; i++) if (keep_in[i]) k_in++;
        h_n        = 32'(hdr_len);
        r_n        = 32'(resid_cnt);
        data_m     = data_in & byte_mask(keep_in);
        first_rest = data_m << (8 * h_n);
        first_t    = (k_in > h_n) ? k_in - h_n : 0;
        body_t     = r_n + k_in;
        body_full  = resid | (data_m >> (8 * r_n));
        body_next  = data_m << (8 * (W - r_n));
        hdr_data   = data_in >> (8 * (W - h_n));
        hdr_keep   = {W{1'b1}} >> (W - h_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hdr_len      <= '0;
            resid        <= '0;
            resid_cnt    <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
        end else begin
            if (valid_out && ready_out) begin
                valid_out <= 1'b0;
                data_out  <= '0;
                keep_out  <= '0;
                last_out  <= 1'b0;
            end
            if (valid_header && ready_header) begin
                valid_header <= 1'b0;
                data_header  <= '0;
                keep_header  <= '0;
            end

            case (state)
                IDLE: begin
                    if (valid_strip) begin
                        hdr_len <= {1'b0, byte_strip_cnt} + CW'(1);
                        state   <= FIRST;
                    end
                end

                FIRST: begin
                    if (accept) begin
                        valid_header <= 1'b1;
                        data_header  <= hdr_data;
                        keep_header  <= hdr_keep;
                        if (!last_in) begin
                            resid     <= first_rest;
                            resid_cnt <= CW'(W - h_n);
                            state     <= BODY;
                        end else begin
                            if (first_t != 0) begin
                                valid_out <= 1'b1;
                                data_out  <= first_rest;
                                keep_out  <= keep_top(first_t);
                                last_out  <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end

                BODY: begin
                    if (accept) begin
                        if (!last_in || body_t > W) begin
                            valid_out <= 1'b1;
                            data_out  <= body_full;
                            keep_out  <= '1;
                            last_out  <= 1'b0;
                            resid     <= body_next;
                            if (last_in) begin
                                resid_cnt <= CW'(body_t - W);
                                state     <= FLUSH;
                            end
                        end else begin
                            if (body_t != 0) begin
                                valid_out <= 1'b1;
                                data_out  <= body_full;
                                keep_out  <= keep_top(body_t);
                                last_out  <= 1'b1;
                            end
                            resid     <= '0;
                            resid_cnt <= '0;
                            state     <= IDLE;
                        end
                    end
                end

                FLUSH: begin
                    if (out_free) begin
                        valid_out <= 1'b1;
                        data_out  <= resid;
                        keep_out  <= keep_top(r_n);
                        last_out  <= 1'b1;
                        resid     <= '0;
                        resid_cnt <= '0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Bench for axi_stream_remove_header: directed vector table, corner sequences and
// randomized packets scored against a byte-queue reference model.
module tb_axi_stream_remove_header;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk, rst;
    logic          valid_in, last_in, ready_in;
    logic [DW-1:0] data_in;
    logic [W-1:0]  keep_in;
    logic          valid_out, last_out, ready_out;
    logic [DW-1:0] data_out;
    logic [W-1:0]  keep_out;
    logic          valid_strip, ready_strip;
    logic [CW-1:0] byte_strip_cnt;
    logic          valid_header, ready_header;
    logic [DW-1:0] data_header;
    logic [W-1:0]  keep_header;

    axi_stream_remove_header #(.DATA_WD(DW)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
        .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
        .ready_header(ready_header)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [35:0] exp_hdr[$];
    logic [36:0] exp_out[$];
    logic [31:0] pd[$];
    logic [3:0]  pk[$];
    bit          bp_rand = 0;

    typedef struct packed {
        int             cnt;
        int             nb;
        logic [2:0][31:0] d;
        logic [2:0][3:0]  k;
        logic [31:0]    hd;
        logic [3:0]     hk;
        int             no;
        logic [2:0][31:0] od;
        logic [2:0][3:0]  ok;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: no handshake within bound, expected one", name);
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < W; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // Output monitor: scoreboard on handshakes, hold-while-stalled and zero-fill checks.
    logic [36:0] op_save;
    logic [35:0] hp_save;
    bit          op_pend = 0, hp_pend = 0;
    always @(negedge clk) begin
        if (rst) begin
            op_pend = 0;
            hp_pend = 0;
        end else begin
            if (op_pend) chk("out_hold", {valid_out, data_out, keep_out, last_out}, {1'b1, op_save});
            if (hp_pend) chk("hdr_hold", {valid_header, data_header, keep_header}, {1'b1, hp_save});
            if (valid_out) chk("out_zero_fill", data_out & ~bmask(keep_out), 0);
            if (valid_header) chk("hdr_zero_fill", data_header & ~bmask(keep_header), 0);
            if (valid_out && ready_out) begin
                if (exp_out.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL out_extra: got beat %h/%h/%b expected none", data_out, keep_out, last_out);
                end else chk("out_beat", {data_out, keep_out, last_out}, exp_out.pop_front());
            end
            if (valid_header && ready_header) begin
                if (exp_hdr.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL hdr_extra: got header %h/%h expected none", data_header, keep_header);
                end else chk("hdr_beat", {data_header, keep_header}, exp_hdr.pop_front());
            end
            op_pend = valid_out && !ready_out;
            op_save = {data_out, keep_out, last_out};
            hp_pend = valid_header && !ready_header;
            hp_save = {data_header, keep_header};
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_rand) begin
            ready_out    = ($urandom % 4) != 0;
            ready_header = ($urandom % 3) != 0;
        end
    end

    task automatic send_strip(input int cnt);
        int n;
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'(cnt);
        n = 0;
        @(negedge clk);
        while (!ready_strip && n < 1000) begin @(negedge clk); n++; end
        if (!ready_strip) timeout_fail("strip_handshake");
        @(posedge clk); #1;
        valid_strip = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit l);
        int n;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        n = 0;
        @(negedge clk);
        while (!ready_in && n < 1000) begin @(negedge clk); n++; end
        if (!ready_in) timeout_fail("beat_handshake");
        @(posedge clk); #1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    endtask

    task automatic send_pkt(input int cnt, input bit gaps);
        send_strip(cnt);
        for (int i = 0; i < pd.size(); i++) begin
            send_beat(pd[i], pk[i], i == pd.size() - 1);
            if (gaps) begin
                repeat ($urandom % 3) @(posedge clk);
                #1;
            end
        end
    endtask

    // Reference: flatten valid bytes, first H are the header, the rest re-chunked W per beat.
    task automatic model_pkt(input int cnt);
        logic [7:0]  b[$];
        logic [31:0] w, hv, dv;
        logic [3:0]  hk, kv;
        int          h, nb, n;
        h = cnt + 1;
        for (int i = 0; i < pd.size(); i++) begin
            w = pd[i];
            for (int j = W - 1; j >= 0; j--) if (pk[i][j]) b.push_back(w[8*j +: 8]);
        end
        nb = b.size();
        hv = '0; hk = '0;
        for (int i = 0; i < h; i++) begin
            hv = {hv[23:0], b[i]};
            hk = {hk[2:0], 1'b1};
        end
        exp_hdr.push_back({hv, hk});
        for (int s = h; s < nb; s += W) begin
            n = (nb - s < W) ? nb - s : W;
            dv = '0; kv = '0;
            for (int j = 0; j < W; j++) begin
                dv = {dv[23:0], (j < n) ? b[s + j] : 8'h00};
                kv = {kv[2:0], 1'(j < n)};
            end
            exp_out.push_back({dv, kv, 1'(s + W >= nb)});
        end
    endtask

    task automatic gen_rand(output int cnt);
        int total, n;
        logic [3:0] k;
        cnt   = $urandom_range(0, 3);
        total = $urandom_range(cnt + 1, 3 * W + 2);
        pd.delete(); pk.delete();
        for (int s = 0; s < total; s += W) begin
            n = (total - s < W) ? total - s : W;
            k = '0;
            for (int j = 0; j < W; j++) k = {k[2:0], 1'(j < n)};
            pd.push_back($urandom);
            pk.push_back(k);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_out.size() != 0 || exp_hdr.size() != 0) && n < 2000) begin
            @(negedge clk); n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_out_left"}, exp_out.size(), 0);
        chk({name, "_hdr_left"}, exp_hdr.size(), 0);
    endtask

    task automatic set_vec(input int i, input int cnt, input int nb,
                           input logic [31:0] d0, d1, d2, input logic [3:0] k0, k1, k2,
                           input logic [31:0] hd, input logic [3:0] hk, input int no,
                           input logic [31:0] o0, o1, o2, input logic [3:0] q0, q1, q2);
        tbl[i].cnt = cnt; tbl[i].nb = nb;
        tbl[i].d[0] = d0; tbl[i].d[1] = d1; tbl[i].d[2] = d2;
        tbl[i].k[0] = k0; tbl[i].k[1] = k1; tbl[i].k[2] = k2;
        tbl[i].hd = hd; tbl[i].hk = hk; tbl[i].no = no;
        tbl[i].od[0] = o0; tbl[i].od[1] = o1; tbl[i].od[2] = o2;
        tbl[i].ok[0] = q0; tbl[i].ok[1] = q1; tbl[i].ok[2] = q2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        vec_t v;
        rst = 1'b1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_strip = 1'b0; byte_strip_cnt = '0;
        ready_out = 1'b1; ready_header = 1'b1;

        set_vec(0, 0, 2, 32'hAABBCCDD, 32'h11223344, 0, 4'hf, 4'hf, 0,
                32'h000000AA, 4'h1, 2, 32'hBBCCDD11, 32'h22334400, 0, 4'hf, 4'he, 0);
        set_vec(1, 3, 2, 32'h12345678, 32'hABCDEF00, 0, 4'hf, 4'hc, 0,
                32'h12345678, 4'hf, 1, 32'hABCD0000, 0, 0, 4'hc, 0, 0);
        set_vec(2, 1, 1, 32'h12345678, 0, 0, 4'he, 0, 0,
                32'h00001234, 4'h3, 1, 32'h56000000, 0, 0, 4'h8, 0, 0);
        set_vec(3, 3, 1, 32'hDEADBEEF, 0, 0, 4'hf, 0, 0,
                32'hDEADBEEF, 4'hf, 0, 0, 0, 0, 0, 0, 0);
        set_vec(4, 2, 3, 32'h01020304, 32'h05060708, 32'h090A0B0C, 4'hf, 4'hf, 4'hf,
                32'h00010203, 4'h7, 3, 32'h04050607, 32'h08090A0B, 32'h0C000000, 4'hf, 4'hf, 4'h8);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {valid_out, data_out, keep_out, last_out, ready_in, ready_strip}, 0);
        chk("rst_header", {valid_header, data_header, keep_header}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready_strip", {ready_strip, ready_in}, 2'b10);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            v = tbl[i];
            exp_hdr.push_back({v.hd, v.hk});
            for (int j = 0; j < v.no; j++) exp_out.push_back({v.od[j], v.ok[j], 1'(j == v.no - 1)});
            pd.delete(); pk.delete();
            for (int j = 0; j < v.nb; j++) begin pd.push_back(v.d[j]); pk.push_back(v.k[j]); end
            send_pkt(v.cnt, 0);
            @(negedge clk);
            chk("latency_out", valid_out, 1'(v.no > 0));
            drain("table");
        end

        // Downstream stall in the middle of a packet.
        pd.delete(); pk.delete();
        pd = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        pk = '{4'hf, 4'hf, 4'hf, 4'hf};
        model_pkt(0);
        ready_out = 1'b0;
        send_strip(0);
        send_beat(pd[0], pk[0], 0);
        send_beat(pd[1], pk[1], 0);
        valid_in = 1'b1; data_in = pd[2]; keep_in = pk[2]; last_in = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready_in", ready_in, 0);
            chk("bp_valid_out", valid_out, 1);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        send_beat(pd[2], pk[2], 0);
        send_beat(pd[3], pk[3], 1);
        drain("backpressure");

        // Unconsumed header stalls the next packet's first beat.
        ready_header = 1'b0;
        pd.delete(); pk.delete();
        pd.push_back(32'hA1B2C3D4); pk.push_back(4'hf);
        model_pkt(1);
        send_pkt(1, 0);
        pd.delete(); pk.delete();
        pd.push_back(32'h55667788); pk.push_back(4'he);
        model_pkt(0);
        send_strip(0);
        valid_in = 1'b1; data_in = pd[0]; keep_in = pk[0]; last_in = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("hdr_stall_ready_in", ready_in, 0);
            chk("hdr_stall_valid_header", valid_header, 1);
        end
        @(posedge clk); #1;
        ready_header = 1'b1;
        send_beat(pd[0], pk[0], 1);
        drain("header_stall");

        // Reset in the middle of a packet discards everything buffered.
        ready_out = 1'b0; ready_header = 1'b0;
        send_strip(1);
        send_beat(32'hCAFEF00D, 4'hf, 0);
        send_beat(32'h0BADBEEF, 4'hf, 0);
        @(negedge clk);
        chk("pre_rst_valid", {valid_out, valid_header}, 2'b11);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out", {valid_out, data_out, keep_out, last_out, ready_in, ready_strip}, 0);
        chk("midrst_hdr", {valid_header, data_header, keep_header}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst", {ready_strip, valid_out, valid_header}, 3'b100);
        @(posedge clk); #1;
        ready_out = 1'b1; ready_header = 1'b1;
        pd.delete(); pk.delete();
        pd = '{32'h10203040, 32'h50607080};
        pk = '{4'hf, 4'hc};
        model_pkt(2);
        send_pkt(2, 0);
        drain("after_reset");

        // Randomized packets with random backpressure on both consumers.
        bp_rand = 1;
        for (int p = 0; p < 40; p++) begin
            gen_rand(cnt);
            model_pkt(cnt);
            send_pkt(cnt, 1);
        end
        bp_rand = 0;
        @(posedge clk); #2;
        ready_out = 1'b1; ready_header = 1'b1;
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
